// File: rtl/ah_arb_pkg.sv
// Shared parameters and types for blocks that consume the 24-way arbiter grant.
// Holds the sizing constants and the grant-mux state encoding.
package ah_arb_pkg;
  localparam int N  = 24;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int CW = 8;
  localparam logic [CW-1:0] MAXB = 8'd255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/ah_onehot_enc.sv
// One-hot to index encoder with exactly-one and multi-hot flags.
// Index is only meaningful when one is high.
module ah_onehot_enc #(
  parameter int N  = 24,
  parameter int IW = 5
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          one,
  output logic          multi
);
  logic any;

  always_comb begin
    idx   = '0;
    any   = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        if (any) multi = 1'b1;
        any = 1'b1;
        idx = idx | IW'(i);
      end
    end
    one = any & ~multi;
  end
endmodule

// File: rtl/ah_grant_mux_24.sv
// Locks onto the arbiter winner and routes its packet to one shared output
// register, pulsing pkt_release to the owner once the last beat has left.
module ah_grant_mux_24
  import ah_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    grant,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic [IW-1:0]   out_src,
  input  logic            out_ready,
  output logic [N-1:0]    pkt_release,
  output logic            busy,
  output logic [7:0]      pkt_beats,
  output logic            err_grant
);
  state_t          state;
  logic [IW-1:0]   sel;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   gidx;
  logic            gone;
  logic            gmulti;
  logic            take;
  logic            acc;
  logic            sel_valid;
  logic            sel_last;
  logic [DW-1:0]   sel_data;

  ah_onehot_enc #(
    .N  (N),
    .IW (IW)
  ) u_enc (
    .vec   (grant),
    .idx   (gidx),
    .one   (gone),
    .multi (gmulti)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == IW'(i)) begin
        sel_valid = in_valid[i];
        sel_last  = in_last[i];
        sel_data  = in_data[i*DW +: DW];
      end
    end
  end

  assign take = ~out_valid | out_ready;
  assign acc  = (state == XFER) & sel_valid & take;
  assign busy = (state != IDLE);

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (state == XFER && sel == IW'(i)) in_ready[i] = take;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_src     <= '0;
      pkt_release <= '0;
      pkt_beats   <= '0;
      err_grant   <= 1'b0;
    end else begin
      pkt_release <= '0;
      if (out_valid & out_ready) out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gone) begin
            state <= XFER;
            sel   <= gidx;
            cnt   <= '0;
          end else if (gmulti) begin
            err_grant <= 1'b1;
          end
        end
        XFER: begin
          if (|grant) err_grant <= 1'b1;
          // a load here overrides the drain clear above
          if (acc) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_src   <= sel;
            if (cnt != MAXB) cnt <= cnt + 1'b1;
            if (sel_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (|grant) err_grant <= 1'b1;
          if (out_valid & out_ready) begin
            pkt_release <= {{(N-1){1'b0}}, 1'b1} << sel;
            pkt_beats   <= cnt;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ah_grant_mux_24.sv
// Directed cycle-by-cycle vectors for ah_grant_mux_24.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_ah_grant_mux_24;
  localparam int N  = 24;
  localparam int DW = 32;
  localparam int IW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    grant;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [IW-1:0]   out_src;
  logic            out_ready;
  logic [N-1:0]    pkt_release;
  logic            busy;
  logic [7:0]      pkt_beats;
  logic            err_grant;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ah_grant_mux_24 dut (
    .clk         (clk),
    .rst         (rst),
    .grant       (grant),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_src     (out_src),
    .out_ready   (out_ready),
    .pkt_release (pkt_release),
    .busy        (busy),
    .pkt_beats   (pkt_beats),
    .err_grant   (err_grant)
  );

  typedef struct {
    logic          rst;
    logic [N-1:0]  grant;
    logic [N-1:0]  vmask;
    int            lane;
    logic [DW-1:0] data;
    logic          last;
    logic          ordy;
    logic [N-1:0]  ir;
    logic          ov;
    logic [DW-1:0] od;
    logic          ol;
    logic [IW-1:0] src;
    logic [N-1:0]  rel;
    logic          busy;
    logic [7:0]    pb;
    logic          err;
  } vec_t;

  function automatic logic [31:0] L(input int i);
    return 32'd1 << i;
  endfunction

  function automatic vec_t mk(
    input logic [31:0] r, g, vm, input int ln,
    input logic [31:0] d, lst, rdy, ir, ov, od, ol, src,
    input logic [31:0] rel, bsy, pb, err);
    vec_t v;
    v.rst   = r[0];
    v.grant = g[N-1:0];
    v.vmask = vm[N-1:0];
    v.lane  = ln;
    v.data  = d;
    v.last  = lst[0];
    v.ordy  = rdy[0];
    v.ir    = ir[N-1:0];
    v.ov    = ov[0];
    v.od    = od;
    v.ol    = ol[0];
    v.src   = src[IW-1:0];
    v.rel   = rel[N-1:0];
    v.busy  = bsy[0];
    v.pb    = pb[7:0];
    v.err   = err[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst       = v.rst;
    grant     = v.grant;
    in_valid  = v.vmask;
    out_ready = v.ordy;
    in_last   = '0;
    if (v.last) in_last[v.lane] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i == v.lane) in_data[i*DW +: DW] = v.data;
      else in_data[i*DW +: DW] = 32'hBAD0_0000 | 32'(i);
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, " in_ready"}, 64'(in_ready), 64'(v.ir));
    chk({tag, " out_valid"}, 64'(out_valid), 64'(v.ov));
    if (v.ov) begin
      chk({tag, " out_data"}, 64'(out_data), 64'(v.od));
      chk({tag, " out_last"}, 64'(out_last), 64'(v.ol));
      chk({tag, " out_src"}, 64'(out_src), 64'(v.src));
    end
    chk({tag, " release"}, 64'(pkt_release), 64'(v.rel));
    chk({tag, " busy"}, 64'(busy), 64'(v.busy));
    chk({tag, " pkt_beats"}, 64'(pkt_beats), 64'(v.pb));
    chk({tag, " err_grant"}, 64'(err_grant), 64'(v.err));
  endtask

  localparam logic [31:0] D0 = 32'hD0D0_0001;
  localparam logic [31:0] D1 = 32'hD1D1_0002;
  localparam logic [31:0] D2 = 32'hD2D2_0003;
  localparam logic [31:0] E0 = 32'hE0E0_0010;
  localparam logic [31:0] E1 = 32'hE1E1_0011;
  localparam logic [31:0] E2 = 32'hE2E2_0012;
  localparam logic [31:0] F0 = 32'hF0F0_0020;
  localparam logic [31:0] G0 = 32'h6060_0030;

  vec_t tv [19];
  logic [31:0] iso;

  initial begin
    iso = L(0) | L(7);
    // lane 5: 3 beats at full rate
    tv[0]  = mk(0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(0, L(5), 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[2]  = mk(0, 0, L(5), 5, D0, 0, 1, L(5), 0, 0, 0, 0, 0, 1, 0, 0);
    tv[3]  = mk(0, 0, L(5), 5, D1, 0, 1, L(5), 1, D0, 0, 5, 0, 1, 0, 0);
    tv[4]  = mk(0, 0, L(5), 5, D2, 1, 1, L(5), 1, D1, 0, 5, 0, 1, 0, 0);
    tv[5]  = mk(0, 0, 0, 5, 0, 0, 1, 0, 1, D2, 1, 5, 0, 1, 0, 0);
    // release to lane 5 while lane 6 is granted back-to-back
    tv[6]  = mk(0, L(6), 0, 6, 0, 0, 1, 0, 0, 0, 0, 0, L(5), 0, 3, 0);
    tv[7]  = mk(0, 0, L(6), 6, E0, 0, 1, L(6), 0, 0, 0, 0, 0, 1, 3, 0);
    tv[8]  = mk(0, 0, L(6), 6, E1, 0, 1, L(6), 1, E0, 0, 6, 0, 1, 3, 0);
    // four stall cycles holding E1 on the output
    tv[9]  = mk(0, 0, L(6), 6, E2, 1, 0, 0, 1, E1, 0, 6, 0, 1, 3, 0);
    tv[10] = tv[9];
    tv[11] = tv[9];
    tv[12] = tv[9];
    tv[13] = mk(0, 0, L(6), 6, E2, 1, 1, L(6), 1, E1, 0, 6, 0, 1, 3, 0);
    tv[14] = mk(0, 0, 0, 6, 0, 0, 1, 0, 1, E2, 1, 6, 0, 1, 3, 0);
    // lane 23 with lanes 0 and 7 pushing; stray grant while in XFER
    tv[15] = mk(0, L(23), iso, 23, 0, 0, 1, 0, 0, 0, 0, 0, L(6), 0, 3, 0);
    tv[16] = mk(0, L(2), iso | L(23), 23, F0, 1, 1,
                L(23), 0, 0, 0, 0, 0, 1, 3, 0);
    tv[17] = mk(0, 0, iso, 23, 0, 0, 1, 0, 1, F0, 1, 23, 0, 1, 3, 1);
    tv[18] = mk(0, 0, iso, 23, 0, 0, 1, 0, 0, 0, 0, 0, L(23), 0, 1, 1);

    drive(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);

    for (int k = 0; k < 19; k++) step($sformatf("v%0d", k), tv[k]);

    // reset mid-packet discards the held beat and issues no release
    step("rA", mk(0, L(3), 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    step("rB", mk(0, 0, L(3), 3, G0, 0, 0, L(3), 0, 0, 0, 0, 0, 1, 1, 1));
    step("rC", mk(1, 0, L(3), 3, G0, 0, 0, 0, 1, G0, 0, 3, 0, 1, 1, 1));
    step("rD", mk(0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // multi-hot grant in IDLE: flagged, no lock taken
    step("mA", mk(0, 32'h11, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("mB", mk(0, 0, L(0) | L(4), 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step("mC", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
